tx_sched: RTL and testbench

Transmit scheduler for the UART hex calculator. It shares the single UART transmitter between two requesters: the echo stream of received bytes, and the ASCII-formatted ALU result. It sits between `rx`/`alu` and `tx`. Echo bytes are buffered in a small FIFO, and each ALU result is serialised as `0x` + hex digits + CR LF. A message is never interleaved with echo traffic.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 43 ++++
 rtl/tx_sched.sv | 167 ++++++++++++++++
 tb/tb_tx_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared FSM state type, ASCII constants and nibble encoder for the UART hex calculator.
package calc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StEcho,
        StPfx0,
        StPfx1,
        StDig,
        StCr,
        StLf
    } tx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] i_nib);
        if (i_nib < 4'd10) begin
            return ASCII_0 + {4'h0, i_nib};
        end
        return ASCII_A + {4'h0, i_nib} - 8'd10;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/tx_sched.sv
// Transmit scheduler: shares the UART transmitter between buffered echo bytes and
// "0x<hex>\r\n" formatted ALU results, never interleaving the two.
module tx_sched
    import calc_pkg::*;
#(
    parameter int unsigned ECHO_DEPTH  = 4,
    parameter bit          LZ_SUPPRESS = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_alu_done,
    input  logic [31:0] i_calc_res,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_echo_ovf,
    output logic        o_res_ovf
);
    tx_state_t   r_state, w_state_d;
    logic [7:0]  r_tx_data, w_tx_data_d;
    logic        r_tx_valid, w_tx_valid_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [31:0] r_res;
    logic        r_pend;
    logic        r_echo_ovf;
    logic        r_res_ovf;

    logic        w_xfer;
    logic        w_pop;
    logic        w_start_msg;
    logic        w_in_msg;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_rdata;
    logic [2:0]  w_start_idx;
    logic [2:0]  w_idx_m1;

    function automatic logic [3:0] res_nibble(input logic [31:0] i_res, input logic [2:0] i_idx);
        return i_res[{i_idx, 2'b00} +: 4];
    endfunction

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_rx_valid),
        .i_wdata (i_rx_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_xfer   = r_tx_valid && i_tx_ready;
    assign w_in_msg = (r_state != StIdle) && (r_state != StEcho);
    assign w_idx_m1 = r_idx - 3'd1;

    always_comb begin
        w_start_idx = 3'd7;
        if (LZ_SUPPRESS) begin
            w_start_idx = 3'd0;
            for (int i = 1; i < 8; i++) begin
                if (res_nibble(r_res, 3'(i)) != 4'h0) w_start_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_tx_data_d  = r_tx_data;
        w_tx_valid_d = r_tx_valid;
        w_idx_d      = r_idx;
        w_pop        = 1'b0;
        w_start_msg  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Echo wins at message boundaries.
                if (!w_fifo_empty) begin
                    w_state_d    = StEcho;
                    w_tx_data_d  = w_fifo_rdata;
                    w_tx_valid_d = 1'b1;
                end else if (r_pend) begin
                    w_state_d    = StPfx0;
                    w_tx_data_d  = ASCII_0;
                    w_tx_valid_d = 1'b1;
                    w_start_msg  = 1'b1;
                end
            end
            StEcho: if (w_xfer) begin
                w_pop        = 1'b1;
                w_state_d    = StIdle;
                w_tx_valid_d = 1'b0;
            end
            StPfx0: if (w_xfer) begin
                w_state_d   = StPfx1;
                w_tx_data_d = ASCII_X;
            end
            StPfx1: if (w_xfer) begin
                w_state_d   = StDig;
                w_idx_d     = w_start_idx;
                w_tx_data_d = nibble_to_ascii(res_nibble(r_res, w_start_idx));
            end
            StDig: if (w_xfer) begin
                if (r_idx == 3'd0) begin
                    w_state_d   = StCr;
                    w_tx_data_d = ASCII_CR;
                end else begin
                    w_idx_d     = w_idx_m1;
                    w_tx_data_d = nibble_to_ascii(res_nibble(r_res, w_idx_m1));
                end
            end
            StCr: if (w_xfer) begin
                w_state_d   = StLf;
                w_tx_data_d = ASCII_LF;
            end
            StLf: if (w_xfer) begin
                w_state_d    = StIdle;
                w_tx_valid_d = 1'b0;
            end
            default: begin
                w_state_d    = StIdle;
                w_tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_idx      <= 3'd0;
            r_res      <= 32'h0;
            r_pend     <= 1'b0;
            r_echo_ovf <= 1'b0;
            r_res_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_valid <= w_tx_valid_d;
            r_idx      <= w_idx_d;
            if (w_start_msg) r_pend <= 1'b0;
            if (i_alu_done) begin
                if (!r_pend && !w_in_msg) begin
                    r_res  <= i_calc_res;
                    r_pend <= 1'b1;
                end else begin
                    r_res_ovf <= 1'b1;
                end
            end
            // Full is judged before any same-cycle pop.
            if (i_rx_valid && w_fifo_full) r_echo_ovf <= 1'b1;
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = (r_state != StIdle) || !w_fifo_empty || r_pend;
    assign o_echo_ovf = r_echo_ovf;
    assign o_res_ovf  = r_res_ovf;

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: two instances (plain and leading-zero suppressed) share stimulus and are
// compared against byte streams built from the message format rules.
module tb_tx_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        alu_done;
    logic [31:0] calc_res;
    logic        tx_ready;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1, busy0, busy1, eovf0, eovf1, rovf0, rovf1;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;

    logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
    logic       stall0 = 1'b0, stall1 = 1'b0;
    logic [7:0] hold0, hold1;

    always #5 clk = ~clk;

    tx_sched #(.ECHO_DEPTH(4), .LZ_SUPPRESS(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_alu_done(alu_done), .i_calc_res(calc_res), .o_tx_data(tx_data0),
        .o_tx_valid(tx_valid0), .i_tx_ready(tx_ready), .o_busy(busy0),
        .o_echo_ovf(eovf0), .o_res_ovf(rovf0)
    );

    tx_sched #(.ECHO_DEPTH(4), .LZ_SUPPRESS(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_alu_done(alu_done), .i_calc_res(calc_res), .o_tx_data(tx_data1),
        .o_tx_valid(tx_valid1), .i_tx_ready(tx_ready), .o_busy(busy1),
        .o_echo_ovf(eovf1), .o_res_ovf(rovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    // Mid-cycle monitor: records bytes that move at the next edge and checks hold under stall.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall0) chk("hold0", {tx_valid0, tx_data0}, {1'b1, hold0});
            if (stall1) chk("hold1", {tx_valid1, tx_data1}, {1'b1, hold1});
            if (tx_valid0 && tx_ready) got0.push_back(tx_data0);
            if (tx_valid1 && tx_ready) got1.push_back(tx_data1);
            stall0 = tx_valid0 && !tx_ready;
            stall1 = tx_valid1 && !tx_ready;
            hold0  = tx_data0;
            hold1  = tx_data1;
        end else begin
            stall0 = 1'b0;
            stall1 = 1'b0;
        end
    end

    task automatic drive_ready();
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 2) == 0);
            default: tx_ready = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_ready();
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        drive_ready();
    endtask

    function automatic logic [7:0] hex(input logic [31:0] v);
        int n = int'(v % 16);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    task automatic add_echo(input logic [7:0] b);
        exp0.push_back(b);
        exp1.push_back(b);
    endtask

    // Expected text for one result: "0x", digits (all 8, or minimal for instance 1), CR LF.
    task automatic add_msg(input logic [31:0] res);
        logic [7:0]  d[$];
        logic [31:0] v;
        v = res;
        add_echo(8'h30);
        add_echo(8'h78);
        for (int i = 7; i >= 0; i--) exp0.push_back(hex(res >> (4 * i)));
        do begin
            d.push_front(hex(v));
            v = v / 16;
        end while (v != 0);
        foreach (d[i]) exp1.push_back(d[i]);
        add_echo(8'h0D);
        add_echo(8'h0A);
    endtask

    task automatic pulse_alu(input logic [31:0] res);
        calc_res = res;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((busy0 || busy1 || tx_valid0 || tx_valid1) && c < 2000) begin
            tick();
            c++;
        end
        chk("drain_timeout", 32'(c < 2000), 32'd1);
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got0.size() < n && c < 200) begin
            tick();
            c++;
        end
        chk("wait_timeout", 32'(c < 200), 32'd1);
    endtask

    task automatic check_streams(input string tag);
        chk({tag, "_len0"}, got0.size(), exp0.size());
        chk({tag, "_len1"}, got1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk({tag, "_b0"}, got0[i], exp0[i]);
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk({tag, "_b1"}, got1[i], exp1[i]);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          ne;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; alu_done = 1'b0; calc_res = 32'h0;
        set_mode(0);
        tick(); tick();
        chk("rst_valid0", tx_valid0, 0); chk("rst_data0", tx_data0, 0); chk("rst_busy0", busy0, 0);
        chk("rst_eovf0", eovf0, 0);      chk("rst_rovf0", rovf0, 0);
        chk("rst_valid1", tx_valid1, 0); chk("rst_data1", tx_data1, 0); chk("rst_busy1", busy1, 0);
        chk("rst_eovf1", eovf1, 0);      chk("rst_rovf1", rovf1, 0);
        rst = 1'b0;
        tick();

        // Single result with exact cycle timing.
        add_msg(32'h0000_12AF);
        pulse_alu(32'h0000_12AF);
        chk("res_lat0", tx_valid0, 0);
        chk("res_lat1", tx_valid1, 0);
        for (int i = 0; i <= 12; i++) begin
            tick();
            if (i < exp0.size()) chk("seq0", {tx_valid0, tx_data0}, {1'b1, exp0[i]});
            else if (i == exp0.size()) chk("gap0", tx_valid0, 0);
            if (i < exp1.size()) chk("seq1", {tx_valid1, tx_data1}, {1'b1, exp1[i]});
            else if (i == exp1.size()) chk("gap1", tx_valid1, 0);
        end
        drain();
        check_streams("single");

        // Zero result.
        add_msg(32'h0);
        pulse_alu(32'h0);
        drain();
        check_streams("zero");

        // Priority: "3+4" with alu_done alongside '4', then echo during the message.
        r = $urandom;
        calc_res = r;
        rx_data = 8'h33; rx_valid = 1'b1; add_echo(8'h33);
        tick();
        chk("echo_lat0", tx_valid0, 0);
        rx_data = 8'h2B; add_echo(8'h2B);
        tick();
        chk("echo_first0", {tx_valid0, tx_data0}, {1'b1, 8'h33});
        chk("echo_first1", {tx_valid1, tx_data1}, {1'b1, 8'h33});
        rx_data = 8'h34; add_echo(8'h34); alu_done = 1'b1;
        tick();
        rx_valid = 1'b0; alu_done = 1'b0;
        add_msg(r);
        wait_got(5);
        for (int k = 0; k < 2; k++) begin
            rx_data = 8'($urandom); rx_valid = 1'b1; add_echo(rx_data);
            tick();
        end
        rx_valid = 1'b0;
        drain();
        check_streams("prio");

        // Backpressure on a known result.
        set_mode(1);
        add_msg(32'h0000_12AF);
        pulse_alu(32'h0000_12AF);
        drain();
        check_streams("bp");
        set_mode(0);

        // Overflow: stalled transmitter, five echo bytes and two results.
        set_mode(2);
        for (int k = 0; k < 5; k++) begin
            rx_data = 8'($urandom); rx_valid = 1'b1;
            if (k < 4) add_echo(rx_data);
            tick();
        end
        rx_valid = 1'b0;
        r = $urandom;
        add_msg(r);
        calc_res = r; alu_done = 1'b1;
        tick();
        calc_res = $urandom;
        tick();
        alu_done = 1'b0;
        chk("echo_ovf0", eovf0, 1); chk("echo_ovf1", eovf1, 1);
        chk("res_ovf0", rovf0, 1);  chk("res_ovf1", rovf1, 1);
        set_mode(0);
        drain();
        check_streams("ovf");

        // Reset right after the 'x' transfer.
        pulse_alu($urandom);
        wait_got(2);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid0", tx_valid0, 0); chk("mid_rst_busy0", busy0, 0);
        chk("mid_rst_eovf0", eovf0, 0);      chk("mid_rst_rovf0", rovf0, 0);
        chk("mid_rst_valid1", tx_valid1, 0); chk("mid_rst_busy1", busy1, 0);
        chk("mid_rst_eovf1", eovf1, 0);      chk("mid_rst_rovf1", rovf1, 0);
        rst = 1'b0;
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        tick(); tick(); tick();
        chk("post_rst_quiet", got0.size() + got1.size(), 0);
        r = $urandom;
        add_msg(r);
        pulse_alu(r);
        drain();
        check_streams("after_rst");

        // Random rounds: a few echo bytes with the result strobed alongside the last one.
        for (int rnd = 0; rnd < 20; rnd++) begin
            set_mode(int'($urandom_range(0, 1)));
            ne = int'($urandom_range(0, 3));
            r = $urandom;
            if ($urandom_range(0, 2) == 0) r = r >> (4 * $urandom_range(1, 7));
            calc_res = r;
            if (ne == 0) begin
                pulse_alu(r);
            end else begin
                for (int k = 0; k < ne; k++) begin
                    rx_data = 8'($urandom); rx_valid = 1'b1; add_echo(rx_data);
                    alu_done = (k == ne - 1);
                    tick();
                end
                rx_valid = 1'b0; alu_done = 1'b0;
            end
            add_msg(r);
            drain();
            check_streams("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
